// File: rtl/core101_pkg.sv
// Shared Core101 definitions: instruction encodings, instruction size, fetch FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package core101_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_OUT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register: loadable, resets to RESET_VECTOR.
// Latency: 1 cycle from i_ld/i_d to o_q.
// Backpressure: none; holds its value whenever i_ld is low.
// Ports: i_clk/i_rst (async active-high), i_ld load enable, i_d next value, o_q current pc.
module fetch_pc_reg #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ld,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_VECTOR;
    end else if (i_ld) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the pc, issues one memory request at a time, presents instr/pc to IF/ID.
// Latency: request at N, rvalid at N+1 earliest, valid_out at N+2; one instruction per 3 cycles peak.
// Backpressure: stall holds the presented instruction in OUT; redirect overrides stall and flushes.
// Ports: clock/reset; redirect valid/target; stall; mem req/addr/gnt/rvalid/rdata;
//        instr/pc/valid to IF/ID; misaligned pulse for the previous cycle's redirect.
module fetch_unit
  import core101_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  fetch_unit_clock_in,
  input  logic                  fetch_unit_reset_in,
  input  logic                  fetch_unit_redirect_valid_in,
  input  logic [DATA_WIDTH-1:0] fetch_unit_redirect_target_in,
  input  logic                  fetch_unit_stall_in,
  output logic                  fetch_unit_mem_req_out,
  output logic [DATA_WIDTH-1:0] fetch_unit_mem_addr_out,
  input  logic                  fetch_unit_mem_gnt_in,
  input  logic                  fetch_unit_mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0] fetch_unit_mem_rdata_in,
  output logic [DATA_WIDTH-1:0] fetch_unit_instr_out,
  output logic [DATA_WIDTH-1:0] fetch_unit_pc_out,
  output logic                  fetch_unit_valid_out,
  output logic                  fetch_unit_misaligned_out
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic                  r_discard;
  logic                  w_discard_nxt;
  logic                  w_pc_ld;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] w_pc;
  logic [DATA_WIDTH-1:0] w_tgt;
  logic                  w_capture;
  logic                  w_valid_nxt;
  logic                  w_req;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc_out;
  logic                  r_valid;
  logic                  r_misaligned;

  // Redirect targets are always word-aligned before use.
  assign w_tgt = {fetch_unit_redirect_target_in[DATA_WIDTH-1:2], 2'b00};

  fetch_pc_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .i_clk(fetch_unit_clock_in),
    .i_rst(fetch_unit_reset_in),
    .i_ld (w_pc_ld),
    .i_d  (w_pc_nxt),
    .o_q  (w_pc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_pc_ld       = 1'b0;
    w_pc_nxt      = w_pc;
    w_capture     = 1'b0;
    w_valid_nxt   = r_valid;
    w_req         = 1'b0;
    case (r_state)
      FETCH_REQ: begin
        w_req = 1'b1;
        if (fetch_unit_redirect_valid_in) begin
          w_pc_ld  = 1'b1;
          w_pc_nxt = w_tgt;
        end
        if (fetch_unit_mem_gnt_in) begin
          // A fetch granted in the same cycle as a redirect is for the old path.
          w_discard_nxt = fetch_unit_redirect_valid_in;
          w_state_nxt   = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (fetch_unit_mem_rvalid_in) begin
          w_discard_nxt = 1'b0;
          if (fetch_unit_redirect_valid_in) begin
            w_pc_ld     = 1'b1;
            w_pc_nxt    = w_tgt;
            w_state_nxt = FETCH_REQ;
          end else if (r_discard) begin
            w_state_nxt = FETCH_REQ;
          end else begin
            w_capture   = 1'b1;
            w_valid_nxt = 1'b1;
            w_pc_ld     = 1'b1;
            w_pc_nxt    = w_pc + DATA_WIDTH'(INSTR_BYTES);
            w_state_nxt = FETCH_OUT;
          end
        end else if (fetch_unit_redirect_valid_in) begin
          // Response still owed; remember to drop it when it lands.
          w_pc_ld       = 1'b1;
          w_pc_nxt      = w_tgt;
          w_discard_nxt = 1'b1;
        end
      end
      FETCH_OUT: begin
        if (fetch_unit_redirect_valid_in) begin
          w_pc_ld     = 1'b1;
          w_pc_nxt    = w_tgt;
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH_REQ;
        end else if (!fetch_unit_stall_in) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH_REQ;
        end
      end
      default: begin
        w_state_nxt   = FETCH_REQ;
        w_discard_nxt = 1'b0;
        w_valid_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge fetch_unit_clock_in or posedge fetch_unit_reset_in) begin
    if (fetch_unit_reset_in) begin
      r_state      <= FETCH_REQ;
      r_discard    <= 1'b0;
      r_instr      <= DATA_WIDTH'(NOP_INSTR);
      r_pc_out     <= RESET_VECTOR;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_discard    <= w_discard_nxt;
      r_valid      <= w_valid_nxt;
      r_misaligned <= fetch_unit_redirect_valid_in & (|fetch_unit_redirect_target_in[1:0]);
      if (w_capture) begin
        r_instr  <= fetch_unit_mem_rdata_in;
        r_pc_out <= w_pc;
      end
    end
  end

  assign fetch_unit_mem_req_out    = w_req;
  assign fetch_unit_mem_addr_out   = w_pc;
  assign fetch_unit_instr_out      = r_instr;
  assign fetch_unit_pc_out         = r_pc_out;
  assign fetch_unit_valid_out      = r_valid;
  assign fetch_unit_misaligned_out = r_misaligned;

endmodule
